pipe_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake, per-stage skid slot and flush.

---
 rtl/pipe_skid_reg.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Parametrised pipeline-stage register with a valid/ready handshake, one skid
// slot per stage and a synchronous flush. DEPTH stages are chained; stage k's
// output feeds stage k+1's input, and in_data reaches out_data DEPTH cycles
// after it is accepted when out_ready is held high.
//
// Handshake: a word moves across any valid/ready pair exactly when both valid
// and ready are high at a rising clk edge. valid never waits on ready, and every
// ready in this block comes from registered stage state only, so there is no
// combinational path from out_ready to in_ready.
//
// Each stage holds a main register M (always the word presented downstream)
// and a skid register S that catches the one word which arrives in the cycle
// the downstream side stalls. The per-stage state is EMPTY / BUSY / FULL.
//
// Parameters
//   WIDTH  payload bits per transfer (>=1)
//   DEPTH  number of chained stages (>=1)
//   CNTW   width of the statistics counters
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset; dominates flush and handshakes
//   flush       synchronous clear of all stages; input taken this cycle is dropped
//   in_valid    upstream payload valid
//   in_ready    stage 0 can accept (not FULL)
//   in_data     upstream payload
//   out_valid   last stage holds a valid payload
//   out_ready   downstream accepts
//   out_data    last-stage payload; reads '0 while out_valid is low
//   stat_xfer   saturating count of out_valid & out_ready cycles
//   stat_stall  saturating count of out_valid & ~out_ready cycles
//   stat_flush  saturating count of flush cycles
//
// Build option
//   PIPE_SKID_STAT_EN  when defined, the three stat_* counters are built
//                      (cleared only by rst). When undefined the stat_* ports
//                      are tied to '0 and no counter flops exist.
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  stat_xfer,
  output logic [CNTW-1:0]  stat_stall,
  output logic [CNTW-1:0]  stat_flush
);

  // EMPTY must encode as zero: reset and flush clear the whole state vector.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [DEPTH-1:0][1:0]       state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] m_q, m_d;
  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;

  // Per-stage registered outputs.
  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_ready;

  // Chains linking neighbouring stages. Index k of vld_chain/dat_chain is the
  // input side of stage k; index k+1 of rdy_chain is the ready seen by stage k.
  logic [DEPTH:0]            vld_chain;
  logic [DEPTH:0]            rdy_chain;
  logic [DEPTH:0][WIDTH-1:0] dat_chain;

  assign vld_chain = {stg_valid, in_valid};
  assign rdy_chain = {out_ready, stg_ready};
  assign dat_chain = {m_q, in_data};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    for (int k = 0; k < DEPTH; k++) begin
      case (state_q[k])
        ST_EMPTY: begin
          if (vld_chain[k]) begin
            state_d[k] = ST_BUSY;
            m_d[k]     = dat_chain[k];
          end
        end
        ST_BUSY: begin
          case ({vld_chain[k], rdy_chain[k+1]})
            2'b11: m_d[k] = dat_chain[k];
            2'b10: begin
              // Downstream stalled while a new word arrived: park it in S.
              state_d[k] = ST_FULL;
              s_d[k]     = dat_chain[k];
            end
            2'b01: begin
              // Drained: clear M so a bubble always reads as zero.
              state_d[k] = ST_EMPTY;
              m_d[k]     = '0;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          // Upstream is held off (ready low); only the downstream side moves.
          if (rdy_chain[k+1]) begin
            state_d[k] = ST_BUSY;
            m_d[k]     = s_q[k];
          end
        end
        default: begin
          // Unused encoding: recover to a clean empty stage.
          state_d[k] = ST_EMPTY;
          m_d[k]     = '0;
          s_d[k]     = '0;
        end
      endcase
    end
    // Flush discards everything, including a word handshaked this cycle.
    if (flush) begin
      state_d = '0;
      m_d     = '0;
      s_d     = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stg_valid[k] = (state_q[k] != ST_EMPTY);
      stg_ready[k] = (state_q[k] != ST_FULL);
    end
    in_ready  = stg_ready[0];
    out_valid = stg_valid[DEPTH-1];
    out_data  = m_q[DEPTH-1];
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef PIPE_SKID_STAT_EN
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [CNTW-1:0] xfer_q, xfer_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic [CNTW-1:0] flushc_q, flushc_d;

  always_comb begin
    xfer_d   = xfer_q;
    stall_d  = stall_q;
    flushc_d = flushc_q;
    // An output handshake during flush still counts as a delivery.
    if (out_valid && out_ready && (xfer_q != CNT_MAX))
      xfer_d = xfer_q + CNT_ONE;
    if (out_valid && !out_ready && (stall_q != CNT_MAX))
      stall_d = stall_q + CNT_ONE;
    if (flush && (flushc_q != CNT_MAX))
      flushc_d = flushc_q + CNT_ONE;
  end

  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_q   <= '0;
      stall_q  <= '0;
      flushc_q <= '0;
    end else begin
      xfer_q   <= xfer_d;
      stall_q  <= stall_d;
      flushc_q <= flushc_d;
    end
  end

  assign stat_xfer  = xfer_q;
  assign stat_stall = stall_q;
  assign stat_flush = flushc_q;
`else
  assign stat_xfer  = '0;
  assign stat_stall = '0;
  assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Bench for pipe_skid_reg with WIDTH=64, DEPTH=2, CNTW=4. The reference model
// treats every stage as a tiny FIFO of capacity two (occupancy plus contents);
// a stage presents its head word, is ready while it holds fewer than two
// words, and all moves between neighbours are decided from the pre-edge
// occupancies. An ordered expected queue checks every delivered word.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;
  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNTW-1:0]  stat_xfer;
  logic [CNTW-1:0]  stat_stall;
  logic [CNTW-1:0]  stat_flush;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stat_xfer  (stat_xfer),
    .stat_stall (stat_stall),
    .stat_flush (stat_flush)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  int               occ[DEPTH];
  logic [WIDTH-1:0] slot[DEPTH][2];
  bit               live = 1'b0;
  int               m_xfer  = 0;
  int               m_stall = 0;
  int               m_flush = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: advances on each rising edge from pre-edge occupancies
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin : model
    bit               in_hs;
    bit               hs[DEPTH];
    logic [WIDTH-1:0] head[DEPTH];
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        occ[k]     = 0;
        slot[k][0] = '0;
        slot[k][1] = '0;
      end
      exp_q.delete();
      m_xfer  = 0;
      m_stall = 0;
      m_flush = 0;
      live    = 1'b1;
    end else begin
      in_hs = in_valid && (occ[0] < 2);
      for (int k = 0; k < DEPTH - 1; k++)
        hs[k] = (occ[k] > 0) && (occ[k+1] < 2);
      hs[DEPTH-1] = (occ[DEPTH-1] > 0) && out_ready;
      for (int k = 0; k < DEPTH; k++)
        head[k] = slot[k][0];
`ifdef PIPE_SKID_STAT_EN
      if (occ[DEPTH-1] > 0) begin
        if (out_ready) begin
          if (m_xfer < CMAX) m_xfer++;
        end else begin
          if (m_stall < CMAX) m_stall++;
        end
      end
      if (flush && (m_flush < CMAX)) m_flush++;
`endif
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          occ[k]     = 0;
          slot[k][0] = '0;
          slot[k][1] = '0;
        end
        exp_q.delete();
      end else begin
        if (in_hs) exp_q.push_back(in_data);
        for (int k = 0; k < DEPTH; k++) begin
          if (hs[k]) begin
            slot[k][0] = slot[k][1];
            slot[k][1] = '0;
            occ[k]--;
          end
        end
        if (in_hs) begin
          slot[0][occ[0]] = in_data;
          occ[0]++;
        end
        for (int k = 1; k < DEPTH; k++) begin
          if (hs[k-1]) begin
            slot[k][occ[k]] = head[k-1];
            occ[k]++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge once the model has seen a reset
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready",  64'(in_ready),  64'(occ[0] < 2));
      chk("out_valid", 64'(out_valid), 64'(occ[DEPTH-1] > 0));
      chk("out_data",  out_data, (occ[DEPTH-1] > 0) ? slot[DEPTH-1][0] : '0);
      chk("stat_xfer",  64'(stat_xfer),  64'(m_xfer));
      chk("stat_stall", 64'(stat_stall), 64'(m_stall));
      chk("stat_flush", 64'(stat_flush), 64'(m_flush));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL order: got %h expected nothing (t=%0t)", out_data, $time);
        end else begin
          chk("order", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push base, base+1, ... with out_ready low until in_ready drops.
  task automatic fill(input logic [WIDTH-1:0] base, output int n);
    int guard;
    n         = 0;
    guard     = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    while (guard < 20) begin
      in_data = base + WIDTH'(n);
      if (!in_ready) break;
      tick();
      n++;
      guard++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int idx;
    int cyc;
    bit acc;

    // Test 1: reset held two cycles with in_valid high, then 0x1..0x8
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hdead;
    out_ready = 1'b0;
    tick();
    tick();
    chk("t1_rst_in_ready",  64'(in_ready),  64'd1);
    chk("t1_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t1_rst_out_data",  out_data,       64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = WIDTH'(i);
      tick();
      if (i == 2) begin
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_latency_data",  out_data,       64'd1);
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t1_count", 64'(got_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk("t1_word", got_q[i], WIDTH'(i + 1));

    // Test 2: 0xA0..0xA9 while out_ready runs 1,0,0,1,0,0,...
    got_q.delete();
    idx      = 0;
    cyc      = 0;
    in_valid = 1'b1;
    while (idx < 10 && cyc < 100) begin
      in_data   = 64'hA0 + WIDTH'(idx);
      out_ready = (cyc % 3 == 0);
      acc       = in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    while (got_q.size() < 10 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      tick();
      cyc++;
    end
    chk("t2_count", 64'(got_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      chk("t2_word", got_q[i], 64'hA0 + WIDTH'(i));

    // Test 3: fill under backpressure, then drain in consecutive cycles
    fill(64'hB0, n);
    chk("t3_accepted", 64'(n), 64'(2 * DEPTH));
    got_q.delete();
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t3_drain_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("t3_word", got_q[i], 64'hB0 + WIDTH'(i));
    chk("t3_in_ready_back", 64'(in_ready), 64'd1);

    // Test 4: flush with all stages full and an input offered
    fill(64'h11, n);
    chk("t4_accepted", 64'(n), 64'd4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h55;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_out_data",  out_data,       64'd0);
    chk("t4_in_ready",  64'(in_ready),  64'd1);
    got_q.delete();
    in_valid  = 1'b1;
    in_data   = 64'h66;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t4_66_valid", 64'(out_valid), 64'd1);
    chk("t4_66_data",  out_data,       64'h66);
    tick();
    chk("t4_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("t4_word", got_q[0], 64'h66);

    // Test 4b: flush in a cycle where the output handshakes
    got_q.delete();
    in_valid = 1'b1;
    in_data  = 64'h70;
    tick();
    in_data = 64'h71;
    tick();
    flush   = 1'b1;
    in_data = 64'h72;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t4b_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("t4b_word", got_q[0], 64'h70);

    // Test 5: rst together with flush and a handshake mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'hC0 + WIDTH'(i);
      tick();
    end
    rst     = 1'b1;
    flush   = 1'b1;
    in_data = 64'hCC;
    tick();
    chk("t5_in_ready",  64'(in_ready),  64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_data",  out_data,       64'd0);
    chk("t5_stat_xfer", 64'(stat_xfer), 64'd0);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;

`ifdef PIPE_SKID_STAT_EN
    // Test 6: stall count, flush count, saturation of the transfer counter
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1;
    tick();
    in_valid = 1'b0;
    tick();
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_stall", 64'(stat_stall), 64'd3);
    chk("t6_xfer1", 64'(stat_xfer),  64'd1);
    chk("t6_flush", 64'(stat_flush), 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 64'hE0 + WIDTH'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t6_xfer_sat", 64'(stat_xfer), 64'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_xfer_kept",  64'(stat_xfer),  64'd15);
    chk("t6_stall_kept", 64'(stat_stall), 64'd3);
    chk("t6_flush2",     64'(stat_flush), 64'd2);
`else
    // Counters are not built: ports must stay zero through traffic and flush
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h5;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("t6_off_xfer",  64'(stat_xfer),  64'd0);
    chk("t6_off_stall", 64'(stat_stall), 64'd0);
    chk("t6_off_flush", 64'(stat_flush), 64'd0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
